// File: rtl/pipe_data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS.
// Each valid access stalls the pipeline for LATENCY cycles. The result appears in the following DONE cycle.
module pipe_data_mem_responder #(
   parameter int LATENCY = 3,
   parameter int DEPTH   = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Mem_Read,
   input  logic        Mem_Write,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   output logic [31:0] Read_Data,
   output logic        Read_Valid,
   output logic        Mem_Stall,
   output logic        Addr_Error
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          wr_q, wr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;

   logic [31:0]   mem [DEPTH];

   logic          req, addr_ok;
   logic          acc_en, acc_wr;
   logic [AW-1:0] acc_idx;
   logic [31:0]   acc_data;

   assign req     = Mem_Read | Mem_Write;
   assign addr_ok = (Address[1:0] == 2'b00) && (Address[31:AW+2] == '0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      wr_d       = wr_q;
      Mem_Stall  = 1'b0;
      Addr_Error = 1'b0;
      acc_en     = 1'b0;
      acc_idx    = idx_q;
      acc_wr     = wr_q;
      acc_data   = wdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (addr_ok) begin
                  Mem_Stall = 1'b1;
                  idx_d     = Address[AW+1:2];
                  wdata_d   = Write_Data;
                  wr_d      = Mem_Write;
                  if (LATENCY == 1) begin
                     // Single-cycle build: the access edge is the capture edge, so use the live inputs
                     state_d  = DONE;
                     acc_en   = 1'b1;
                     acc_idx  = Address[AW+1:2];
                     acc_wr   = Mem_Write;
                     acc_data = Write_Data;
                  end else begin
                     cnt_d   = 4'(LATENCY - 1);
                     state_d = BUSY;
                  end
               end else begin
                  Addr_Error = 1'b1;
               end
            end
         end
         BUSY: begin
            Mem_Stall = 1'b1;
            cnt_d     = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               acc_en  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = acc_en && !acc_wr;
      if (acc_en && !acc_wr) rdata_d = mem[acc_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Storage is not reset; a write is only committed while out of reset
   always_ff @(posedge clk) begin
      if (acc_en && acc_wr && rst_n) mem[acc_idx] <= acc_data;
   end

   assign Read_Data  = rdata_q;
   assign Read_Valid = rvalid_q;
endmodule
